// File: rtl/element_addition_cut_bipolar_f_pkg.sv
// Shared binary32 definitions for the HDC bundling datapath: field widths,
// constants, unpacked-float view and FSM state encoding.
// Honours ELEMENT_ADD_DENORM_EN: subnormals keep their significand instead of
// being flushed to signed zero on unpack.
package hdc_fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  localparam logic [31:0] FP32_POS_ONE = {1'b0, FP_BIAS[7:0], 23'd0};
  localparam logic [31:0] FP32_NEG_ONE = {1'b1, FP_BIAS[7:0], 23'd0};
  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;   // effective exponent (1 for subnormals when kept)
    logic [FP_MAN_W:0]   sig;   // significand including hidden bit
    logic                is_nan;
    logic                is_inf;
  } fp_unp_t;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ALIGN = 3'd1;
  localparam state_t ST_ADD   = 3'd2;
  localparam state_t ST_NORM  = 3'd3;
  localparam state_t ST_ROUND = 3'd4;
  localparam state_t ST_CUT   = 3'd5;
  localparam state_t ST_DONE  = 3'd6;

  function automatic fp_unp_t fp_unpack(input logic [31:0] x);
    fp_unp_t u;
    u.sign   = x[31];
    u.is_nan = (&x[30:23]) && (|x[22:0]);
    u.is_inf = (&x[30:23]) && !(|x[22:0]);
    if (x[30:23] == 8'd0) begin
`ifdef ELEMENT_ADD_DENORM_EN
      u.exp = 8'd1;
      u.sig = {1'b0, x[22:0]};
`else
      u.exp = 8'd0;
      u.sig = 24'd0;
`endif
    end else begin
      u.exp = x[30:23];
      u.sig = {1'b1, x[22:0]};
    end
    return u;
  endfunction

endpackage

// File: rtl/element_addition_cut_bipolar_f_if.sv
// Element stream / result bus between the HV streamer, this kernel and the quantiser.
interface element_addition_cut_bipolar_f_if #(parameter int W = 32);
  logic         valid;
  logic         first;
  logic         last;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         ready;
  logic         done;

  modport master (output valid, first, last, data_in, input data_out, ready, done);
  modport slave  (input valid, first, last, data_in, output data_out, ready, done);
endinterface

// File: rtl/element_addition_cut_bipolar_f_fp32_add.sv
// Four-stage binary32 adder (align, add, normalise, round), round-to-nearest-even.
// start latches the operands; finish is high during the round cycle with result valid.
// Honours ELEMENT_ADD_DENORM_EN: gradual underflow instead of flush-to-zero.
module fp32_add_multicycle
  import hdc_fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        finish,
  output logic [31:0] result
);

  logic [3:0]  stg;
  fp_unp_t     ua, ub;
  fp_unp_t     big, sml;
  logic [7:0]  diff;
  logic [49:0] sh_wide;
  logic [26:0] small_al;
  logic        sp_nan, sp_inf, sp_inf_sign;

  logic        al_sign, al_sub;
  logic [7:0]  al_exp;
  logic [26:0] al_mb, al_ms;
  logic [2:0]  al_sp, ad_sp, nm_sp;   // {nan, inf, inf sign}

  logic [27:0] sum;
  logic [27:0] ad_sum;
  logic        ad_sign;
  logic [7:0]  ad_exp;

  logic [4:0]  lz;
  logic [26:0] nm_m, nm_m_q;
  logic [8:0]  nm_e, nm_e_q;
  logic        nm_zero, nm_zero_q, nm_sign_q;

  logic        round_up;
  logic [24:0] rm;
  logic [8:0]  rexp;

  // stage occupancy shift: bit0 align, bit1 add, bit2 normalise, bit3 round
  always_ff @(posedge clk or posedge rst)
    if (rst) stg <= '0;
    else     stg <= {stg[2:0], start};

  assign finish = stg[3];

  // operand capture at accept
  always_ff @(posedge clk)
    if (start) begin
      ua <= fp_unpack(a);
      ub <= fp_unpack(b);
    end

  assign big      = ({ua.exp, ua.sig} >= {ub.exp, ub.sig}) ? ua : ub;
  assign sml      = ({ua.exp, ua.sig} >= {ub.exp, ub.sig}) ? ub : ua;
  assign diff     = big.exp - sml.exp;
  assign sh_wide  = {sml.sig, 26'd0} >> diff;
  assign small_al = (diff >= 8'd50) ? {26'd0, |sml.sig} : {sh_wide[49:24], |sh_wide[23:0]};
  assign sp_nan      = ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_inf & (ua.sign ^ ub.sign));
  assign sp_inf      = ua.is_inf | ub.is_inf;
  assign sp_inf_sign = ua.is_inf ? ua.sign : ub.sign;

  // align stage registers
  always_ff @(posedge clk) begin
    al_sign <= big.sign;
    al_sub  <= big.sign ^ sml.sign;
    al_exp  <= big.exp;
    al_mb   <= {big.sig, 3'b000};
    al_ms   <= small_al;
    al_sp   <= {sp_nan, sp_inf, sp_inf_sign};
  end

  assign sum = al_sub ? ({1'b0, al_mb} - {1'b0, al_ms}) : ({1'b0, al_mb} + {1'b0, al_ms});

  // add stage registers; exact cancellation yields +0
  always_ff @(posedge clk) begin
    ad_sum  <= sum;
    ad_sign <= (al_sub && sum == 28'd0) ? 1'b0 : al_sign;
    ad_exp  <= al_exp;
    ad_sp   <= al_sp;
  end

  // leading-zero count over the non-carry part of the sum
  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++)
      if (ad_sum[i]) lz = 5'(26 - i);
  end

  // normalise: carry shifts right with sticky, otherwise shift left by lz
  always_comb begin
    nm_m    = ad_sum[26:0];
    nm_e    = {1'b0, ad_exp};
    nm_zero = 1'b0;
    if (ad_sum[27]) begin
      nm_m = {ad_sum[27:2], ad_sum[1] | ad_sum[0]};
      nm_e = {1'b0, ad_exp} + 9'd1;
    end else if (ad_sum[26:0] == 27'd0) begin
      nm_zero = 1'b1;
    end else if ({3'b000, lz} >= ad_exp) begin
`ifdef ELEMENT_ADD_DENORM_EN
      nm_m = ad_sum[26:0] << (ad_exp - 8'd1);
      nm_e = 9'd0;
`else
      nm_zero = 1'b1;
`endif
    end else begin
      nm_m = ad_sum[26:0] << lz;
      nm_e = {1'b0, ad_exp} - {4'b0000, lz};
    end
  end

  // normalise stage registers
  always_ff @(posedge clk) begin
    nm_m_q    <= nm_m;
    nm_e_q    <= nm_e;
    nm_zero_q <= nm_zero;
    nm_sign_q <= ad_sign;
    nm_sp     <= ad_sp;
  end

  assign round_up = nm_m_q[2] & (nm_m_q[3] | nm_m_q[1] | nm_m_q[0]);
  assign rm       = {1'b0, nm_m_q[26:3]} + {24'd0, round_up};
  assign rexp     = (nm_e_q == 9'd0) ? {8'd0, rm[23]} : nm_e_q + {8'd0, rm[24]};

  // round and pack, specials first, exponent overflow saturates to infinity
  always_comb begin
    if (nm_sp[2])                result = FP32_QNAN;
    else if (nm_sp[1])           result = {nm_sp[0], 8'hFF, 23'd0};
    else if (nm_zero_q)          result = {nm_sign_q, 31'd0};
    else if (rexp >= 9'd255)     result = {nm_sign_q, 8'hFF, 23'd0};
    else                         result = {nm_sign_q, rexp[7:0], rm[24] ? rm[23:1] : rm[22:0]};
  end

endmodule

// File: rtl/element_addition_cut_bipolar_f.sv
// Bundling kernel: accumulates a first/last framed stream of binary32 elements,
// clips the final sum to [CUT_NEG, CUT_POS] and presents it with a done pulse.
// ELEMENT_ADD_DENORM_EN (in the adder/package) enables gradual underflow.
module element_addition_cut_bipolar_f
  import hdc_fp_pkg::*;
#(
  parameter int          HV_DATA_WIDTH = 32,
  parameter logic [31:0] CUT_POS       = FP32_POS_ONE,
  parameter logic [31:0] CUT_NEG       = FP32_NEG_ONE
) (
  input logic                            clk,
  input logic                            reset,
  element_addition_cut_bipolar_f_if.slave bus
);

  state_t                   state;
  logic                     last_q;
  logic [HV_DATA_WIDTH-1:0] acc;
  logic [HV_DATA_WIDTH-1:0] out_q;
  logic [HV_DATA_WIDTH-1:0] cut_val;
  logic [31:0]              add_res;
  logic                     add_fin;
  logic                     accept;

  assign accept = (state == ST_IDLE) && bus.valid;

  fp32_add_multicycle u_add (
    .clk    (clk),
    .rst    (reset),
    .start  (accept),
    .a      (bus.first ? 32'h0000_0000 : acc),
    .b      (bus.data_in),
    .finish (add_fin),
    .result (add_res)
  );

  // sign-magnitude clip; NaN is passed through untouched
  always_comb begin
    cut_val = acc;
    if ((&acc[30:23]) && (|acc[22:0]))             cut_val = acc;
    else if (!acc[31] && acc[30:0] > CUT_POS[30:0]) cut_val = CUT_POS;
    else if (acc[31] && acc[30:0] > CUT_NEG[30:0])  cut_val = CUT_NEG;
  end

  // sequencing FSM, accumulator and held output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      last_q <= 1'b0;
      acc    <= '0;
      out_q  <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (bus.valid) begin
                    last_q <= bus.last;
                    state  <= ST_ALIGN;
                  end
        ST_ALIGN: state <= ST_ADD;
        ST_ADD:   state <= ST_NORM;
        ST_NORM:  state <= ST_ROUND;
        ST_ROUND: if (add_fin) begin
                    acc   <= add_res;
                    state <= last_q ? ST_CUT : ST_IDLE;
                  end
        ST_CUT:   begin
                    out_q <= cut_val;
                    state <= ST_DONE;
                  end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready    = (state == ST_IDLE);
  assign bus.done     = (state == ST_DONE);
  assign bus.data_out = out_q;

endmodule

// File: tb/tb_element_addition_cut_bipolar_f.sv
// Scoreboard bench: expected clipped sums are queued when a stream's last
// element is issued; a monitor pops and compares on every done pulse.
module tb_element_addition_cut_bipolar_f;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  element_addition_cut_bipolar_f_if #(.W(32)) bus ();

  element_addition_cut_bipolar_f dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          low;
  int          done_at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // monitor: every done pulse consumes one scoreboard entry
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got data_out 0x%08h, expected no done pulse", bus.data_out);
      end else begin
        check(name_q.pop_front(), bus.data_out, exp_q.pop_front());
      end
    end
  end

  task automatic expect_result(input string name, input logic [31:0] v);
    exp_q.push_back(v);
    name_q.push_back(name);
  endtask

  task automatic send(input logic [31:0] d, input logic f, input logic l);
    int t = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got ready %b, expected 1", bus.ready);
    end
    bus.valid   = 1'b1;
    bus.first   = f;
    bus.last    = l;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.first = 1'b0;
    bus.last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got %0d done pulses, expected %0d", done_cnt, target);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.valid   = 1'b0;
    bus.first   = 1'b0;
    bus.last    = 1'b0;
    bus.data_in = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_ready", {31'd0, bus.ready}, 32'd1);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_data_out", bus.data_out, 32'h0);
    reset = 1'b0;

    // 0.5 + 0.25
    expect_result("sum_0p75", 32'h3F40_0000);
    send(32'h3F00_0000, 1'b1, 1'b0);
    send(32'h3E80_0000, 1'b0, 1'b1);
    wait_done(1);

    // 1.0 + -1.0, with valid pulses during the busy window that must be dropped
    send(32'h3F80_0000, 1'b1, 1'b0);
    low = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (!bus.ready) low++;
      if (i < 4) begin
        bus.valid = 1'b1; bus.first = 1'b1; bus.last = 1'b1; bus.data_in = 32'h4000_0000;
      end else begin
        bus.valid = 1'b0; bus.first = 1'b0; bus.last = 1'b0;
      end
    end
    check("busy_cycles_elem", low, 32'd4);
    @(negedge clk);
    check("ready_after_elem", {31'd0, bus.ready}, 32'd1);
    expect_result("cancel_to_zero", 32'h0000_0000);
    send(32'hBF80_0000, 1'b0, 1'b1);
    wait_done(2);

    // 0.75 + 0.75 = 1.5, clipped to +1.0
    expect_result("cut_pos", 32'h3F80_0000);
    send(32'h3F40_0000, 1'b1, 1'b0);
    send(32'h3F40_0000, 1'b0, 1'b1);
    wait_done(3);

    // no first: continues from the unclipped accumulator 1.5, -0.75 -> 0.75
    expect_result("continue_acc", 32'h3F40_0000);
    send(32'hBF40_0000, 1'b0, 1'b1);
    wait_done(4);

    // -1.5 + -0.25 = -1.75, clipped to -1.0
    expect_result("cut_neg", 32'hBF80_0000);
    send(32'hBFC0_0000, 1'b1, 1'b0);
    send(32'hBE80_0000, 1'b0, 1'b1);
    wait_done(5);

    // single element with first=last: occupancy and latency
    expect_result("single_elem", 32'h3E80_0000);
    send(32'h3E80_0000, 1'b1, 1'b1);
    low = 0;
    done_at = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (!bus.ready) low++;
      if (bus.done && done_at == 0) done_at = i;
    end
    check("busy_cycles_single", low, 32'd6);
    check("done_latency", done_at, 32'd6);
    wait_done(6);

    // overflow to +inf, clipped to +1.0
    expect_result("overflow_cut", 32'h3F80_0000);
    send(32'h7F7F_FFFF, 1'b1, 1'b0);
    send(32'h7F7F_FFFF, 1'b0, 1'b1);
    wait_done(7);

    // NaN operand passes through the clip
    expect_result("nan_pass", 32'h7FC0_0000);
    send(32'h7FC0_0000, 1'b1, 1'b0);
    send(32'h3F80_0000, 1'b0, 1'b1);
    wait_done(8);

    // reset during ADD of the last element of a 3-element stream
    send(32'h3F00_0000, 1'b1, 1'b0);
    send(32'h3F00_0000, 1'b0, 1'b0);
    send(32'h3F00_0000, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, bus.ready}, 32'd1);
    check("abort_data_out", bus.data_out, 32'h0);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt, 32'd8);

    // fresh 2-element stream after the abort: 0.5 + -0.25
    expect_result("after_abort", 32'h3E80_0000);
    send(32'h3F00_0000, 1'b1, 1'b0);
    send(32'hBE80_0000, 1'b0, 1'b1);
    wait_done(9);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("total_done", done_cnt, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
